// File: rtl/fp_mult_arbiter.sv
// fp_mult_arbiter
//   Round-robin sequencer that shares one half-precision multiplier between
//   NREQ requesters. It captures the winner's operands, runs the multiplier's
//   start/done/ack handshake and returns the product as a tagged one-cycle
//   response. Every output is driven straight from a register.
//
// Ports
//   clk, reset      clock; asynchronous active-high reset (shared with the multiplier)
//   req             per-requester request, held until that requester's grant pulse
//   req_a, req_b    packed operands, slice i = [16*i+15:16*i]
//   grant           one-hot pulse: operands of that requester were captured
//   rsp_valid       one-hot pulse: rsp_z is the product for that requester
//   rsp_z           last product, held until the next response
//   busy            high whenever the sequencer is not idle
//   grant_id        index of the current/last granted requester
//   mul_start/a/b   to the multiplier (start pulse and held operands)
//   mul_z/mul_done  from the multiplier
//   mul_ack         to the multiplier, one-cycle pulse after done is seen
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no transaction; pick a winner as soon as any req is high
// S_START | grant and mul_start pulses are out; drop them next cycle
// S_WAIT  | multiplier running; operands held; wait for mul_done
// S_DRAIN | response and ack issued; wait for mul_done to fall

module fp_mult_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_a,
  input  logic [16*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      grant,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [15:0]          rsp_z,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 mul_start,
  output logic [15:0]          mul_a,
  output logic [15:0]          mul_b,
  input  logic [15:0]          mul_z,
  input  logic                 mul_done,
  output logic                 mul_ack
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_WAIT  = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t            state_q;
  logic [IDW-1:0]    ptr_q;
  logic [NREQ-1:0]   grant_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [15:0]       rsp_z_q;
  logic              busy_q;
  logic [IDW-1:0]    grant_id_q;
  logic              mul_start_q;
  logic [15:0]       mul_a_q;
  logic [15:0]       mul_b_q;
  logic              mul_ack_q;

  // Winner selection: rotate req so the pointer position sits at bit 0,
  // take the lowest set bit, then rotate the offset back.
  logic [NREQ-1:0]   rot;
  logic [IDW-1:0]    off;
  logic [IDW:0]      sum;
  logic [IDW-1:0]    win_d;
  logic [IDW-1:0]    ptr_d;
  logic [15:0]       sel_a_d;
  logic [15:0]       sel_b_d;

  always_comb begin
    rot = NREQ'({req, req} >> ptr_q);
    off = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDW'(i);
    end
    sum = {1'b0, ptr_q} + {1'b0, off};
    if (sum >= (IDW+1)'(NREQ)) sum = sum - (IDW+1)'(NREQ);
    win_d = sum[IDW-1:0];
    ptr_d = (win_d == IDW'(NREQ - 1)) ? '0 : win_d + IDW'(1);
    sel_a_d = '0;
    sel_b_d = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_d == IDW'(i)) begin
        sel_a_d = req_a[16*i +: 16];
        sel_b_d = req_b[16*i +: 16];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      grant_q     <= '0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      busy_q      <= 1'b0;
      grant_id_q  <= '0;
      mul_start_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_ack_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req != '0) begin
            mul_a_q     <= sel_a_d;
            mul_b_q     <= sel_b_d;
            grant_id_q  <= win_d;
            grant_q     <= NREQ'(1) << win_d;
            mul_start_q <= 1'b1;
            ptr_q       <= ptr_d;
            busy_q      <= 1'b1;
            state_q     <= S_START;
          end
        end
        S_START: begin
          grant_q     <= '0;
          mul_start_q <= 1'b0;
          state_q     <= S_WAIT;
        end
        S_WAIT: begin
          if (mul_done) begin
            rsp_z_q     <= mul_z;
            rsp_valid_q <= NREQ'(1) << grant_id_q;
            mul_ack_q   <= 1'b1;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          rsp_valid_q <= '0;
          mul_ack_q   <= 1'b0;
          // done lingers for a cycle after ack; leaving early would let the
          // next transaction see a stale done.
          if (!mul_done) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant     = grant_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_z     = rsp_z_q;
  assign busy      = busy_q;
  assign grant_id  = grant_id_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_ack   = mul_ack_q;

endmodule

// File: tb/tb_fp_mult_arbiter.sv
// Testbench for fp_mult_arbiter: bench-side multiplier model plus a
// round-robin reference model kept as plain modular arithmetic.

module tb_fp_mult_arbiter;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic [NREQ-1:0]     req = '0;
  logic [16*NREQ-1:0]  req_a = '0;
  logic [16*NREQ-1:0]  req_b = '0;
  logic [NREQ-1:0]     grant;
  logic [NREQ-1:0]     rsp_valid;
  logic [15:0]         rsp_z;
  logic                busy;
  logic [IDW-1:0]      grant_id;
  logic                mul_start;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic [15:0]         mul_z;
  logic                mul_done;
  logic                mul_ack;

  int n_checks = 0;
  int n_pass   = 0;
  int n_start  = 0;
  int n_ack    = 0;
  int exp_ptr  = 0;
  int m_lat    = 6;
  int m_hold   = 1;
  int m_st;
  int m_cnt;

  typedef struct {
    int          id;
    logic [15:0] z;
  } exp_t;

  fp_mult_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a(req_a), .req_b(req_b),
    .grant(grant), .rsp_valid(rsp_valid), .rsp_z(rsp_z), .busy(busy),
    .grant_id(grant_id), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_z(mul_z), .mul_done(mul_done), .mul_ack(mul_ack)
  );

  always #5 clk = ~clk;

  // Stand-in product: exact for multiplication by 1.0, a fixed scramble otherwise.
  function automatic logic [15:0] f_mul(input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h3C00) return b;
    if (b == 16'h3C00) return a;
    return a ^ {b[7:0], b[15:8]} ^ 16'h1234;
  endfunction

  function automatic int rr_pick(input logic [NREQ-1:0] r, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (r[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] oh(input int i);
    logic [NREQ-1:0] v;
    v = '0;
    if (i >= 0) v[i] = 1'b1;
    return v;
  endfunction

  // Multiplier model: done after m_lat cycles, held until ack, then m_hold more cycles.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_st <= 0; m_cnt <= 0; mul_done <= 1'b0; mul_z <= '0;
    end else begin
      case (m_st)
        0: if (mul_start) begin m_cnt <= m_lat - 1; m_st <= 1; end
        1: if (m_cnt == 0) begin
             mul_done <= 1'b1; mul_z <= f_mul(mul_a, mul_b); m_st <= 2;
           end else m_cnt <= m_cnt - 1;
        2: if (mul_ack) begin m_cnt <= m_hold - 1; m_st <= 3; end
        default: if (m_cnt == 0) begin mul_done <= 1'b0; m_st <= 0; end
                 else m_cnt <= m_cnt - 1;
      endcase
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    if (mul_start) n_start++;
    if (mul_ack) n_ack++;
  endtask

  task automatic set_ops(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic new_ops(input int i);
    logic [15:0] a;
    a = 16'($urandom);
    if ($urandom_range(0, 7) == 0) a = '0;
    set_ops(i, a, 16'($urandom));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    exp_ptr = 0;
  endtask

  // Drives nothing but the grant-drop; collects what one transaction looked like.
  task automatic run_txn(input logic keep, output int g_lat, output logic [NREQ-1:0] g,
                         output logic [IDW-1:0] gid, output logic [15:0] ga,
                         output int n_rsp, output logic [NREQ-1:0] rv,
                         output logic [15:0] rz, output logic done_ok);
    g_lat = -1; g = '0; gid = '0; ga = '0; n_rsp = 0; rv = '0; rz = '0; done_ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      step();
      if (grant != '0) begin
        g_lat = c; g = grant; gid = grant_id; ga = mul_a;
        break;
      end
    end
    if (g_lat >= 0) begin
      if (!keep) req = req & ~g;
      for (int c = 0; c < 80; c++) begin
        step();
        if (rsp_valid != '0) begin n_rsp++; rv = rsp_valid; rz = rsp_z; end
        if (!busy) begin done_ok = 1'b1; break; end
      end
    end
  endtask

  task automatic test_reset();
    step();
    n_checks++; if (grant !== '0) $display("FAIL rst_grant: got %b exp 0", grant); else n_pass++;
    n_checks++; if (rsp_valid !== '0) $display("FAIL rst_rsp_valid: got %b exp 0", rsp_valid); else n_pass++;
    n_checks++; if (rsp_z !== '0) $display("FAIL rst_rsp_z: got %h exp 0", rsp_z); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b exp 0", busy); else n_pass++;
    n_checks++; if (grant_id !== '0) $display("FAIL rst_grant_id: got %0d exp 0", grant_id); else n_pass++;
    n_checks++; if ({mul_start, mul_ack} !== 2'b00) $display("FAIL rst_start_ack: got %b exp 00", {mul_start, mul_ack}); else n_pass++;
    n_checks++; if ({mul_a, mul_b} !== '0) $display("FAIL rst_mul_ab: got %h exp 0", {mul_a, mul_b}); else n_pass++;
    req = 4'b1111;
    step();
    n_checks++; if ({grant, busy} !== '0) $display("FAIL rst_dominates_req: got %b exp 0", {grant, busy}); else n_pass++;
    req = '0;
    reset = 1'b0;
    step();
    step();
    n_checks++; if ({grant, busy, mul_start} !== '0) $display("FAIL idle_no_req: got %b exp 0", {grant, busy, mul_start}); else n_pass++;
  endtask

  task automatic test_single();
    int g_lat, n_rsp; logic [NREQ-1:0] g, rv; logic [IDW-1:0] gid; logic [15:0] ga, rz; logic ok;
    m_lat = 6; m_hold = 1; n_start = 0; n_ack = 0;
    set_ops(0, 16'h3C00, 16'h4000);
    req = 4'b0001;
    run_txn(1'b0, g_lat, g, gid, ga, n_rsp, rv, rz, ok);
    n_checks++; if (g !== 4'b0001) $display("FAIL single_grant: got %b exp 0001", g); else n_pass++;
    n_checks++; if (g_lat !== 0) $display("FAIL single_grant_latency: got %0d exp 0", g_lat); else n_pass++;
    n_checks++; if (ga !== 16'h3C00) $display("FAIL single_mul_a: got %h exp 3c00", ga); else n_pass++;
    n_checks++; if (n_start !== 1) $display("FAIL single_start_pulses: got %0d exp 1", n_start); else n_pass++;
    n_checks++; if (n_rsp !== 1 || rv !== 4'b0001) $display("FAIL single_rsp_valid: got %0d x %b exp 1 x 0001", n_rsp, rv); else n_pass++;
    n_checks++; if (rz !== 16'h4000) $display("FAIL single_rsp_z: got %h exp 4000", rz); else n_pass++;
    n_checks++; if (n_ack !== 1) $display("FAIL single_ack_pulses: got %0d exp 1", n_ack); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL single_busy_drop: got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_round_robin();
    int g_lat, n_rsp, e; logic [NREQ-1:0] g, rv; logic [IDW-1:0] gid; logic [15:0] ga, rz; logic ok;
    apply_reset();
    m_lat = 2; m_hold = 1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    req = 4'b1111;
    for (int t = 0; t < 8; t++) begin
      e = rr_pick(req, exp_ptr);
      run_txn(1'b1, g_lat, g, gid, ga, n_rsp, rv, rz, ok);
      n_checks++; if (g !== oh(e) || gid !== IDW'(e)) $display("FAIL rr_grant_%0d: got %b id %0d exp %b id %0d", t, g, gid, oh(e), e); else n_pass++;
      n_checks++; if (rv !== oh(int'(gid)) || n_rsp !== 1) $display("FAIL rr_rsp_tag_%0d: got %b x %0d exp %b x 1", t, rv, n_rsp, oh(int'(gid))); else n_pass++;
      n_checks++; if (rz !== f_mul(req_a[16*e +: 16], req_b[16*e +: 16])) $display("FAIL rr_rsp_z_%0d: got %h exp %h", t, rz, f_mul(req_a[16*e +: 16], req_b[16*e +: 16])); else n_pass++;
      n_checks++; if (ok !== 1'b1) $display("FAIL rr_idle_%0d: got %b exp 1", t, ok); else n_pass++;
      exp_ptr = (e + 1) % NREQ;
    end
    req = '0;
  endtask

  task automatic test_wrap_skip();
    int g_lat, n_rsp; logic [NREQ-1:0] g, rv; logic [IDW-1:0] gid; logic [15:0] ga, rz; logic ok;
    logic [NREQ-1:0] exp_g [5];
    logic [NREQ-1:0] set_r [5];
    exp_g = '{4'b0100, 4'b0001, 4'b0100, 4'b1000, 4'b0001};
    set_r = '{4'b0100, 4'b0101, 4'b0000, 4'b1000, 4'b1111};
    apply_reset();
    m_lat = 3; m_hold = 1;
    for (int i = 0; i < NREQ; i++) new_ops(i);
    // 0100 parks the pointer at 3; 0101 then wraps to 0 before 2; 1000 wraps it back to 0.
    for (int t = 0; t < 5; t++) begin
      if (set_r[t] != '0) req = set_r[t];
      run_txn(1'b0, g_lat, g, gid, ga, n_rsp, rv, rz, ok);
      n_checks++; if (g !== exp_g[t] || rv !== exp_g[t] || !ok) $display("FAIL wrap_skip_%0d: got grant %b rsp %b idle %b exp %b", t, g, rv, ok, exp_g[t]); else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_operand_stability();
    int bad; logic [15:0] rz; logic ok;
    bad = 0; rz = '0; ok = 1'b0;
    m_lat = 5; m_hold = 1;
    set_ops(0, 16'h3C00, 16'h4200);
    req = 4'b0001;
    step();
    n_checks++; if (grant !== 4'b0001) $display("FAIL stab_grant: got %b exp 0001", grant); else n_pass++;
    req = '0;
    step();
    req_a[15:0] = 16'h4400;
    for (int c = 0; c < 60; c++) begin
      step();
      if (busy && mul_a !== 16'h3C00) bad++;
      if (rsp_valid != '0) rz = rsp_z;
      if (!busy) begin ok = 1'b1; break; end
    end
    n_checks++; if (bad !== 0) $display("FAIL stab_mul_a_changes: got %0d exp 0", bad); else n_pass++;
    n_checks++; if (rz !== 16'h4200 || !ok) $display("FAIL stab_rsp_z: got %h idle %b exp 4200 idle 1", rz, ok); else n_pass++;
  endtask

  task automatic test_done_hold();
    int nrsp, bad_g, bad_b; logic [NREQ-1:0] g1, g2; logic ok;
    nrsp = 0; bad_g = 0; bad_b = 0; g1 = '0; g2 = '0; ok = 1'b0;
    apply_reset();
    m_lat = 3; m_hold = 3; n_ack = 0;
    set_ops(1, 16'h4100, 16'h4500);
    set_ops(2, 16'h3800, 16'h4600);
    req = 4'b0110;
    for (int c = 0; c < 80; c++) begin
      step();
      if (n_ack > 0 && mul_done) begin
        if (!busy) bad_b++;
        if (grant != '0) bad_g++;
      end
      if (rsp_valid != '0) nrsp++;
      if (grant != '0) begin
        if (g1 == '0) begin g1 = grant; req = req & ~grant; end
        else begin g2 = grant; break; end
      end
    end
    n_checks++; if (g1 !== 4'b0010) $display("FAIL dh_first_grant: got %b exp 0010", g1); else n_pass++;
    n_checks++; if (nrsp !== 1) $display("FAIL dh_rsp_count: got %0d exp 1", nrsp); else n_pass++;
    n_checks++; if (n_ack !== 1) $display("FAIL dh_ack_count: got %0d exp 1", n_ack); else n_pass++;
    n_checks++; if (bad_b !== 0) $display("FAIL dh_idle_while_done: got %0d exp 0", bad_b); else n_pass++;
    n_checks++; if (bad_g !== 0) $display("FAIL dh_grant_while_done: got %0d exp 0", bad_g); else n_pass++;
    n_checks++; if (g2 !== 4'b0100) $display("FAIL dh_second_grant: got %b exp 0100", g2); else n_pass++;
    req = '0;
    for (int c = 0; c < 80; c++) begin
      step();
      if (!busy) begin ok = 1'b1; break; end
    end
    n_checks++; if (ok !== 1'b1) $display("FAIL dh_second_idle: got %b exp 1", ok); else n_pass++;
    m_hold = 1;
  endtask

  task automatic test_async_reset();
    int g_lat, n_rsp; logic [NREQ-1:0] g, rv; logic [IDW-1:0] gid; logic [15:0] ga, rz; logic ok;
    m_lat = 12; m_hold = 1;
    set_ops(1, 16'h4200, 16'h4400);
    req = 4'b0010;
    step();
    n_checks++; if (grant !== 4'b0010) $display("FAIL ar_grant_before: got %b exp 0010", grant); else n_pass++;
    req = '0;
    for (int c = 0; c < 4; c++) step();
    n_checks++; if (busy !== 1'b1 || mul_a !== 16'h4200) $display("FAIL ar_in_wait: got busy %b a %h exp 1 4200", busy, mul_a); else n_pass++;
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({grant, rsp_valid, rsp_z, busy, grant_id, mul_start, mul_a, mul_b, mul_ack} !== '0)
      $display("FAIL ar_outputs_cleared: got %h exp 0", {grant, rsp_valid, rsp_z, busy, grant_id, mul_start, mul_a, mul_b, mul_ack});
    else n_pass++;
    req = 4'b0010;
    step();
    step();
    n_checks++; if ({grant, rsp_valid, busy} !== '0) $display("FAIL ar_held_in_reset: got %b exp 0", {grant, rsp_valid, busy}); else n_pass++;
    reset = 1'b0;
    run_txn(1'b0, g_lat, g, gid, ga, n_rsp, rv, rz, ok);
    n_checks++; if (g !== 4'b0010 || g_lat !== 0) $display("FAIL ar_regrant: got %b lat %0d exp 0010 lat 0", g, g_lat); else n_pass++;
    n_checks++; if (rv !== 4'b0010 || n_rsp !== 1 || rz !== f_mul(16'h4200, 16'h4400)) $display("FAIL ar_rsp: got %b x %0d z %h exp 0010 x 1 z %h", rv, n_rsp, rz, f_mul(16'h4200, 16'h4400)); else n_pass++;
    n_checks++; if (ok !== 1'b1) $display("FAIL ar_idle: got %b exp 1", ok); else n_pass++;
  endtask

  task automatic test_random();
    exp_t q[$];
    exp_t e;
    int exp_id, n_gr;
    logic [NREQ-1:0] seen;
    n_gr = 0;
    apply_reset();
    req = '0;
    for (int c = 0; c < 2400; c++) begin
      m_lat  = int'($urandom_range(1, 8));
      m_hold = int'($urandom_range(1, 3));
      step();
      seen = req;
      exp_id = -1;
      if (grant != '0) begin
        exp_id = rr_pick(seen, exp_ptr);
        n_checks++;
        if (grant !== oh(exp_id)) $display("FAIL rand_grant: cycle %0d got %b exp %b (req %b)", c, grant, oh(exp_id), seen);
        else n_pass++;
        if (exp_id >= 0) begin
          e.id = exp_id;
          e.z  = f_mul(req_a[16*exp_id +: 16], req_b[16*exp_id +: 16]);
          q.push_back(e);
          exp_ptr = (exp_id + 1) % NREQ;
          n_gr++;
          if (c < 2000 && $urandom_range(0, 3) == 0) new_ops(exp_id);
          else req[exp_id] = 1'b0;
        end
      end
      if (rsp_valid != '0) begin
        n_checks++;
        if (q.size() == 0) $display("FAIL rand_rsp_unexpected: got %b exp none", rsp_valid);
        else begin
          e = q.pop_front();
          if ({rsp_valid, rsp_z} !== {oh(e.id), e.z})
            $display("FAIL rand_rsp: got %b z %h exp %b z %h", rsp_valid, rsp_z, oh(e.id), e.z);
          else n_pass++;
        end
      end
      if (c < 2000) begin
        for (int i = 0; i < NREQ; i++) begin
          if (i != exp_id) begin
            if (!req[i] && $urandom_range(0, 3) == 0) begin new_ops(i); req[i] = 1'b1; end
            else if (req[i] && $urandom_range(0, 39) == 0) req[i] = 1'b0;
          end
        end
      end else begin
        req = '0;
        if (q.size() == 0 && !busy) break;
      end
    end
    n_checks++; if (q.size() !== 0) $display("FAIL rand_outstanding: got %0d exp 0", q.size()); else n_pass++;
    n_checks++; if (n_gr < 50) $display("FAIL rand_progress: got %0d grants exp >= 50", n_gr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_wrap_skip();
    test_operand_stability();
    test_done_hold();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
